// File: rtl/joypad_responder_pkg.sv
// Shared CPU-bus types for the controller responder: register addresses,
// the open-bus pattern and the NES button bit order.
package joypad_responder_pkg;

  localparam logic [15:0] JOY_ADDR1    = 16'h4016;
  localparam logic [15:0] JOY_ADDR2    = 16'h4017;
  localparam logic [7:0]  OPEN_BUS_JOY = 8'h40;

  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_UP     = 3'd4,
    BTN_DOWN   = 3'd5,
    BTN_LEFT   = 3'd6,
    BTN_RIGHT  = 3'd7
  } btn_idx_e;

endpackage

// File: rtl/joypad_responder_port.sv
// One controller port: two-flop button synchronizer feeding an 8-bit
// parallel-load shift register that fills with 1s as it is read out.
module joypad_port
  import joypad_responder_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clock_en,
  input  logic [7:0] btn,
  input  logic       strobe,
  input  logic       shift_req,
  output logic       serial
);

  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;
  logic [7:0] shift_q, shift_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    sync1_d = sync1_q;
    sync2_d = sync2_q;
    shift_d = shift_q;
    if (clock_en) begin
      sync1_d = btn;
      sync2_d = sync1_q;
      if (strobe) begin
        shift_d = sync2_q;
      end else if (shift_req) begin
        shift_d = {1'b1, shift_q[7:1]};
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
      shift_q <= 8'hFF;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      shift_q <= shift_d;
    end
  end

  // While strobed, the register is continuously reloading, so the live A button shows.
  assign serial = strobe ? sync2_q[BTN_A] : shift_q[0];

endmodule

// File: rtl/joypad_responder.sv
// CPU-bus responder for the NES controller registers at $4016/$4017:
// address decode, strobe register and the registered read port.
module joypad_responder
  import joypad_responder_pkg::*;
#(
  parameter logic [15:0] CTRL1_ADDR = JOY_ADDR1,
  parameter logic [15:0] CTRL2_ADDR = JOY_ADDR2,
  parameter logic [7:0]  OPEN_BUS   = OPEN_BUS_JOY
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clock_en,
  input  logic [15:0] addr,
  input  logic        r_en,
  input  logic        w_en,
  input  logic [7:0]  w_data,
  input  logic [7:0]  btn1,
  input  logic [7:0]  btn2,
  output logic [7:0]  r_data,
  output logic        r_hit
);

  logic       hit1, hit2;
  logic       serial1, serial2;
  logic       strobe_q, strobe_d;
  logic [7:0] r_data_q, r_data_d;
  logic       r_hit_q, r_hit_d;

  assign hit1 = (addr == CTRL1_ADDR);
  assign hit2 = (addr == CTRL2_ADDR);

  joypad_port u_port1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .clock_en  (clock_en),
    .btn       (btn1),
    .strobe    (strobe_q),
    .shift_req (r_en && hit1),
    .serial    (serial1)
  );

  joypad_port u_port2 (
    .clock     (clock),
    .reset_n   (reset_n),
    .clock_en  (clock_en),
    .btn       (btn2),
    .strobe    (strobe_q),
    .shift_req (r_en && hit2),
    .serial    (serial2)
  );

  always_comb begin
    strobe_d = strobe_q;
    r_data_d = r_data_q;
    r_hit_d  = r_hit_q;
    if (clock_en) begin
      // A read in the same cycle wins; the write is dropped.
      if (w_en && !r_en && hit1) begin
        strobe_d = w_data[0];
      end
      r_hit_d = r_en && (hit1 || hit2);
      if (r_en && hit1) begin
        r_data_d = OPEN_BUS | {7'b0, serial1};
      end else if (r_en && hit2) begin
        r_data_d = OPEN_BUS | {7'b0, serial2};
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      r_data_q <= 8'h00;
      r_hit_q  <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
      r_data_q <= r_data_d;
      r_hit_q  <= r_hit_d;
    end
  end

  assign r_data = r_data_q;
  assign r_hit  = r_hit_q;

  rw_collision_a : assert property (@(posedge clock) disable iff (!reset_n)
    !(clock_en && r_en && w_en && (hit1 || hit2)))
    else $warning("joypad_responder: simultaneous read and write, write dropped");

endmodule

// File: tb/tb_joypad_responder.sv
// Self-checking bench for joypad_responder: directed plan steps plus a
// randomized phase, all compared against a read-index reference model.
module tb_joypad_responder;

  logic        clock;
  logic        reset_n;
  logic        clock_en;
  logic [15:0] addr;
  logic        r_en;
  logic        w_en;
  logic [7:0]  w_data;
  logic [7:0]  btn1;
  logic [7:0]  btn2;
  logic [7:0]  r_data;
  logic        r_hit;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: latched byte plus count of reads since the latch.
  logic       m_strobe;
  logic [7:0] m_lat [2];
  int         m_idx [2];
  logic [7:0] m_s1  [2];
  logic [7:0] m_s2  [2];
  logic [7:0] m_rdata;
  logic       m_rhit;

  joypad_responder dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .clock_en (clock_en),
    .addr     (addr),
    .r_en     (r_en),
    .w_en     (w_en),
    .w_data   (w_data),
    .btn1     (btn1),
    .btn2     (btn2),
    .r_data   (r_data),
    .r_hit    (r_hit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_strobe = 1'b0;
    m_rdata  = 8'h00;
    m_rhit   = 1'b0;
    for (int q = 0; q < 2; q++) begin
      m_lat[q] = 8'hFF;
      m_idx[q] = 0;
      m_s1[q]  = 8'h00;
      m_s2[q]  = 8'h00;
    end
  endtask

  task automatic model_edge();
    int   p;
    logic bit_v;
    if (!clock_en) return;
    p = -1;
    if (r_en && addr == 16'h4016) p = 0;
    else if (r_en && addr == 16'h4017) p = 1;
    m_rhit = (p >= 0);
    if (p >= 0) begin
      if (m_strobe) bit_v = m_s2[p][0];
      else bit_v = (m_idx[p] < 8) ? m_lat[p][m_idx[p]] : 1'b1;
      m_rdata = 8'h40 | {7'b0, bit_v};
      if (!m_strobe && m_idx[p] < 8) m_idx[p]++;
    end
    if (m_strobe) begin
      for (int q = 0; q < 2; q++) begin
        m_lat[q] = m_s2[q];
        m_idx[q] = 0;
      end
    end
    if (w_en && !r_en && addr == 16'h4016) m_strobe = w_data[0];
    m_s2[0] = m_s1[0];
    m_s2[1] = m_s1[1];
    m_s1[0] = btn1;
    m_s1[1] = btn2;
  endtask

  task automatic step(input logic ce, input logic re, input logic we,
                      input logic [15:0] a, input logic [7:0] wd);
    @(negedge clock);
    clock_en = ce;
    r_en     = re;
    w_en     = we;
    addr     = a;
    w_data   = wd;
    @(posedge clock);
    model_edge();
    #1;
    check("r_hit", {7'b0, r_hit}, {7'b0, m_rhit});
    check("r_data", r_data, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic rd(input logic [15:0] a);
    step(1'b1, 1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    step(1'b1, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    logic [7:0] exp_seq [10];
    logic [15:0] ra;
    int op;

    reset_n  = 1'b0;
    clock_en = 1'b0;
    addr     = 16'h0000;
    r_en     = 1'b0;
    w_en     = 1'b0;
    w_data   = 8'h00;
    btn1     = 8'h00;
    btn2     = 8'h00;
    model_reset();
    #12;
    check("reset_r_data", r_data, 8'h00);
    check("reset_r_hit", {7'b0, r_hit}, 8'h00);
    #10 reset_n = 1'b1;

    // Read without strobe: shift register holds its reset 1s.
    rd(16'h4016);
    check("plan_first_read", r_data, 8'h41);
    check("plan_first_hit", {7'b0, r_hit}, 8'h01);
    idle(1);
    check("plan_idle_hit", {7'b0, r_hit}, 8'h00);
    check("plan_idle_hold", r_data, 8'h41);

    // Unmapped address never hits.
    rd(16'h4015);
    check("plan_other_addr", {7'b0, r_hit}, 8'h00);

    // A+Start latched and serialized, then 1-fill.
    btn1 = 8'b0000_1001;
    idle(3);
    wr(16'h4016, 8'h01);
    wr(16'h4016, 8'h00);
    exp_seq = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
    for (int i = 0; i < 10; i++) begin
      rd(16'h4016);
      check("plan_serial_a_start", r_data, exp_seq[i]);
    end

    // Strobe held high: reads show the synchronized live A bit.
    btn1 = 8'h00;
    wr(16'h4016, 8'h01);
    idle(3);
    rd(16'h4016);
    check("plan_live_a_before", r_data, 8'h40);
    btn1 = 8'h01;
    rd(16'h4016);
    check("plan_live_a_sync1", r_data, 8'h40);
    rd(16'h4016);
    check("plan_live_a_sync2", r_data, 8'h40);
    rd(16'h4016);
    check("plan_live_a_after", r_data, 8'h41);

    // Port 2 Right button; port 1 is not shifted by port-2 reads.
    btn2 = 8'h80;
    idle(3);
    wr(16'h4016, 8'h00);
    for (int i = 0; i < 8; i++) begin
      rd(16'h4017);
      check("plan_port2_right", r_data, (i == 7) ? 8'h41 : 8'h40);
    end
    rd(16'h4016);
    check("plan_port1_untouched0", r_data, 8'h41);
    rd(16'h4016);
    check("plan_port1_untouched1", r_data, 8'h40);

    // clock_en low mid-stream freezes everything.
    btn1 = 8'h05;
    idle(3);
    wr(16'h4016, 8'h01);
    wr(16'h4016, 8'h00);
    rd(16'h4016);
    check("plan_ce_pre0", r_data, 8'h41);
    rd(16'h4016);
    check("plan_ce_pre1", r_data, 8'h40);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h4016, 8'h00);
      check("plan_ce_hold_data", r_data, 8'h40);
      check("plan_ce_hold_hit", {7'b0, r_hit}, 8'h01);
    end
    rd(16'h4016);
    check("plan_ce_resume0", r_data, 8'h41);
    rd(16'h4016);
    check("plan_ce_resume1", r_data, 8'h40);

    // Asynchronous reset after three reads of a latched 00.
    btn1 = 8'h00;
    idle(3);
    wr(16'h4016, 8'h01);
    wr(16'h4016, 8'h00);
    for (int i = 0; i < 3; i++) begin
      rd(16'h4016);
      check("plan_zero_reads", r_data, 8'h40);
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("plan_async_r_data", r_data, 8'h00);
    check("plan_async_r_hit", {7'b0, r_hit}, 8'h00);
    #2 reset_n = 1'b1;
    rd(16'h4016);
    check("plan_post_reset_read", r_data, 8'h41);
    // A write to $4017 must not raise the strobe (live A is 0 here).
    wr(16'h4017, 8'h01);
    idle(2);
    rd(16'h4016);
    check("plan_4017_write_ignored", r_data, 8'h41);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) btn1 = 8'($urandom);
      if ($urandom_range(0, 9) == 0) btn2 = 8'($urandom);
      case ($urandom_range(0, 4))
        0, 1: ra = 16'h4016;
        2, 3: ra = 16'h4017;
        default: begin
          ra = 16'($urandom);
          if (ra == 16'h4016 || ra == 16'h4017) ra = 16'h4018;
        end
      endcase
      op = $urandom_range(0, 3);
      step($urandom_range(0, 7) != 0, op == 1 || op == 3, op == 2, ra, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/joypad_responder.md
Name: joypad_responder

Overview:
- CPU-bus responder for the two NES controller ports at $4016/$4017.
- Sits beside cpu_memory on the core's addr / r_en / w_data bus and answers the core's accesses to the controller registers.
- Synchronizes host-supplied button state, then latches it on the strobe write.
- Serializes one button bit per CPU read, with NES-accurate read side effects.

Parameters:
- CTRL1_ADDR, 16'h4016, address of controller-1 data register and the strobe register.
- CTRL2_ADDR, 16'h4017, address of controller-2 data register; writes here are ignored because they belong to the APU.
- OPEN_BUS, 8'h40, constant upper bits returned on reads; bit0 is always replaced by the serial bit.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- clock_en  input  1  qualifies every state update; no state changes when low
- addr  input  16  CPU address
- r_en  input  1  CPU read strobe for this cycle
- w_en  input  1  CPU write strobe for this cycle
- w_data  input  8  CPU write data
- btn1  input  8  controller-1 buttons, active-high, asynchronous; bit order {Right,Left,Down,Up,Start,Select,B,A} = [7:0]
- btn2  input  8  controller-2 buttons, same order
- r_data  output  8  read data, registered
- r_hit  output  1  registered; high when r_data is valid from this block; drives the bus read mux

Behaviour:
- Reset (async, reset_n low): r_data=8'h00, r_hit=0, strobe=0, both shift regs=8'hFF, both sync chains=8'h00.
- Synchronizer:
  - btn1 and btn2 each pass through 2 flops (btnN_s).
  - A button edge on the input is visible to latching 2 enabled cycles later.
- Strobe register:
  - On a clock_en cycle with w_en=1, r_en=0 and addr==CTRL1_ADDR: strobe <= w_data[0]. Other w_data bits are ignored.
  - While strobe=1, every enabled cycle reloads shiftN <= btnN_s for both ports.
  - The cycle strobe goes 1->0, the final reload still occurs, using the value from that same cycle.
- Read at CTRL1_ADDR (r_en=1, clock_en=1):
  - Next edge: r_data <= OPEN_BUS | {7'b0, shift1[0]}; r_hit <= 1.
  - If strobe=0, shift1 <= {1'b1, shift1[7:1]} on the same edge.
  - If strobe=1, no shift occurs and the data bit is btn1_s[0], the live A button.
- Read at CTRL2_ADDR: identical behaviour on port 2.
- After 8 reads without a reload, the ports return 1 indefinitely (8'h41).
- Read latency: 1 cycle.
  - r_hit and r_data are updated only on enabled cycles.
  - On an enabled cycle with no hit, r_hit <= 0 and r_data holds its previous value.
- Simultaneous r_en=1 and w_en=1: the read is serviced and the write is dropped. A simulation assertion flags this case.
- Back-to-back reads on consecutive cycles each shift once. There is no dead cycle.
- clock_en=0: all registers hold, including the synchronizer, and r_hit holds its value.
- Reset mid-sequence: all state returns to reset values immediately, and the next read returns 8'h41.
- Any address other than the two parameters: no effect, r_hit <= 0.

Decomposition:
- Shared package (cpu-types): constants JOY_ADDR1 and JOY_ADDR2, the button-index enum (BTN_A=0 .. BTN_RIGHT=7), and OPEN_BUS_JOY.
- One sub-module, joypad_port, instantiated twice. It contains:
  - 2-flop button sync
  - 8-bit shift register with 1-fill
  - inputs strobe, shift_req, clock_en
  - output serial bit
- The top holds the address decode, the strobe register and the r_data/r_hit registers.

Test Plan:
- Reset, then read $4016 with no strobe -> r_data=8'h41, r_hit=1 one cycle later; r_hit=0 the cycle after an idle cycle.
- btn1=8'b0000_1001 (A+Start), wait 3 cycles, write $4016=01 then 00, then 10 reads of $4016 -> bits 1,0,0,1,0,0,0,0,1,1, i.e. r_data 41,40,40,41,40,40,40,40,41,41.
- Strobe held at 1, btn1 toggles A 0->1, three reads -> each returns the live A bit after 2-cycle sync (40 before, 41 after) and no shifting occurs.
- btn2=8'h80 (Right), strobe 1->0, 8 reads of $4017 -> seven 8'h40 then 8'h41; port-1 state is unchanged when checked afterward.
- clock_en=0 for 5 cycles during a read stream -> no shift and r_data held; sequence resumes exactly when clock_en=1.
- reset_n pulsed after 3 reads of a latched 8'h00 -> outputs cleared asynchronously; next read returns 8'h41. Also check a write to $4017=01 leaves strobe unchanged.
